// File: rtl/vga_sdm_modulator.sv
// vga_sdm_modulator: 2-stage first-order sigma-delta modulator turning 8-bit VGA r/g/b into 1-bit streams.
// Optional LFSR input dither is built when VGA_SDM_DITHER_EN is defined.
module sdm_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blank,
  input  logic             bypass,
  input  logic [WIDTH-1:0] lvl,
  input  logic             msb,
  output logic             sd
);
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, lvl};

  // accumulator runs through bypass so the stream picks up seamlessly when bypass drops
  always_ff @(posedge clk) begin
    if (reset || blank) begin
      acc <= '0;
      sd  <= 1'b0;
    end else begin
      acc <= sum[WIDTH-1:0];
      sd  <= bypass ? msb : sum[WIDTH];
    end
  end
endmodule

module vga_sdm_modulator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bypass,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblank_in,
  input  logic             vblank_in,
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             sd_r,
  output logic             sd_g,
  output logic             sd_b,
  output logic             hsync,
  output logic             vsync,
  output logic             blank
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0][WIDTH-1:0] s1_lvl;
  logic [NUM_LANES-1:0][WIDTH-1:0] eff_lvl;
  logic [NUM_LANES-1:0]            sd;
  logic s1_bypass, s1_hsync, s1_vsync, s1_blank;

  // lane 0 = red, 1 = green, 2 = blue
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_lvl    <= '0;
      s1_bypass <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_blank  <= 1'b1;
    end else begin
      s1_lvl    <= {b_in, g_in, r_in};
      s1_bypass <= bypass;
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
      s1_blank  <= hblank_in | vblank_in;
    end
  end

`ifdef VGA_SDM_DITHER_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset)          lfsr <= 8'hA5;
    else if (!s1_blank) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // dither saturates at full scale rather than wrapping a bright pixel to black
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_dith
    logic [WIDTH:0] dsum;
    assign dsum       = {1'b0, s1_lvl[i]} + {{(WIDTH-1){1'b0}}, lfsr[1:0]};
    assign eff_lvl[i] = dsum[WIDTH] ? {WIDTH{1'b1}} : dsum[WIDTH-1:0];
  end
`else
  assign eff_lvl = s1_lvl;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sdm_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .blank  (s1_blank),
      .bypass (s1_bypass),
      .lvl    (eff_lvl[i]),
      .msb    (s1_lvl[i][WIDTH-1]),
      .sd     (sd[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
      blank <= 1'b1;
    end else begin
      hsync <= s1_hsync;
      vsync <= s1_vsync;
      blank <= s1_blank;
    end
  end

  assign sd_r = sd[0];
  assign sd_g = sd[1];
  assign sd_b = sd[2];
endmodule

// File: tb/tb_vga_sdm_modulator.sv
// Scoreboard bench for vga_sdm_modulator: per-cycle expected outputs queued at drive time, popped after each edge.
module tb_vga_sdm_modulator;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset, bypass, hsync_in, vsync_in, hblank_in, vblank_in;
  logic [W-1:0] r_in, g_in, b_in;
  logic sd_r, sd_g, sd_b, hsync, vsync, blank;

  vga_sdm_modulator #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .bypass(bypass),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .sd_r(sd_r), .sd_g(sd_g), .sd_b(sd_b), .hsync(hsync), .vsync(vsync), .blank(blank)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sd;   // {r, g, b}
    logic       hs;
    logic       vs;
    logic       bl;
  } exp_t;

  exp_t       q[$];
  logic [2:0] obs[$];
  logic [2:0] obs_a[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         m_acc[3];
  logic [7:0] m_lfsr;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one pixel clock: drive, queue the expectation, then score the output of the previous pixel
  task automatic step(input logic rst, input logic byp, input logic hs, input logic vs,
                      input logic hb, input logic vb,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    exp_t e;
    logic [7:0] lv[3];
    int eff, sum;
    reset = rst; bypass = byp; hsync_in = hs; vsync_in = vs;
    hblank_in = hb; vblank_in = vb; r_in = r; g_in = g; b_in = b;
    lv[0] = r; lv[1] = g; lv[2] = b;
    e = '0;
    if (rst) begin
      e.bl = 1'b1;
      for (int c = 0; c < 3; c++) m_acc[c] = 0;
      m_lfsr = 8'hA5;
    end else begin
      e.hs = hs; e.vs = vs; e.bl = hb | vb;
      for (int c = 0; c < 3; c++) begin
        if (e.bl) begin
          m_acc[c] = 0;
        end else begin
          eff = int'(lv[c]);
`ifdef VGA_SDM_DITHER_EN
          eff = eff + int'(m_lfsr[1:0]);
          if (eff > 255) eff = 255;
`endif
          sum = m_acc[c] + eff;
          e.sd[2-c] = byp ? lv[c][7] : (sum >= 256);
          m_acc[c] = sum % 256;
        end
      end
      if (!e.bl) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      check("reset_vals", {10'd0, sd_r, sd_g, sd_b, hsync, vsync, blank}, 16'h0001);
      if (q.size() > 1) void'(q.pop_front());
    end else if (q.size() > 1) begin
      e = q.pop_front();
      check("pipe", {10'd0, sd_r, sd_g, sd_b, hsync, vsync, blank}, {10'd0, e});
      obs.push_back({sd_r, sd_g, sd_b});
    end
  endtask

  task automatic do_reset(input int n);
    obs.delete();
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic run(input int n, input logic byp, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int i = 0; i < n; i++) step(0, byp, 0, 0, 0, 0, r, g, b);
  endtask

  function automatic int count_ones(input int lane, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(obs[i][lane]);
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; bypass = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    hblank_in = 1'b0; vblank_in = 1'b0; r_in = '0; g_in = '0; b_in = '0;

    // black, no blanking
    do_reset(3);
    run(20, 0, 8'h00, 8'h00, 8'h00);
    check("black_ones", 16'(count_ones(2, 0, 19) + count_ones(1, 0, 19) + count_ones(0, 0, 19)), 16'd0);

    // mid-scale red
    do_reset(3);
    run(300, 0, 8'h80, 8'h00, 8'h00);
`ifndef VGA_SDM_DITHER_EN
    check("r80_seq", {12'd0, obs[1][2], obs[2][2], obs[3][2], obs[4][2]}, 16'b0101);
    check("r80_duty", 16'(count_ones(2, 2, 257)), 16'd128);
`endif

    // extreme green / blue
    do_reset(3);
    run(520, 0, 8'h00, 8'h01, 8'hFF);
`ifndef VGA_SDM_DITHER_EN
    check("g01_ones", 16'(count_ones(1, 1, 512)), 16'd2);
    check("g01_pos", {14'd0, obs[256][1], obs[512][1]}, 16'b11);
    check("bff_zeros", 16'(512 - count_ones(0, 1, 512)), 16'd2);
`endif

    // hblank pulse inside a red line, with sync toggling
    do_reset(3);
    for (int i = 0; i < 36; i++)
      step(0, 0, i[1], i[2], (i >= 20 && i < 24), 0, 8'h55, 8'h00, 8'h00);
`ifndef VGA_SDM_DITHER_EN
    check("hb_zero", 16'(count_ones(2, 21, 24)), 16'd0);
    check("hb_restart", {12'd0, obs[25][2], obs[26][2], obs[27][2], obs[28][2]}, 16'b0001);
`endif

    // bypass then resume
    do_reset(3);
    run(10, 1, 8'h80, 8'h00, 8'h00);
    run(10, 1, 8'h7F, 8'h00, 8'h00);
    run(10, 0, 8'h80, 8'h00, 8'h00);
    check("byp_80", 16'(count_ones(2, 1, 10)), 16'd10);
    check("byp_7f", 16'(count_ones(2, 11, 20)), 16'd0);

    // mid-line reset must replay the fresh-reset sequence exactly
    do_reset(1);
    run(37, 0, 8'h80, 8'h01, 8'h55);
    obs_a = obs;
    do_reset(1);
    run(37, 0, 8'h80, 8'h01, 8'h55);
    check("replay_len", 16'(obs.size()), 16'(obs_a.size()));
    for (int i = 0; i < obs_a.size() && i < obs.size(); i++)
      check("replay_bits", {13'd0, obs[i]}, {13'd0, obs_a[i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
